// File: rtl/writeback.sv
// writeback: round-robin arbitration of ALU and LSU results into the register-file write port.
// Optional WB_RETIRE_CNT_EN adds a free-running retired-write counter output.
module writeback #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [4:0]      alu_rd_i,
  output logic            alu_ok_o,
  input  logic            mem_valid_i,
  input  logic [XLEN-1:0] mem_result_i,
  input  logic [4:0]      mem_rd_i,
  output logic            mem_ok_o,
  input  logic            flush,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic [31:0]     busy_clr_o
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]     retire_cnt_o
`endif
);
  typedef enum logic {SRC_ALU, SRC_MEM} src_e;
  logic            alu_v_q, alu_v_d, mem_v_q, mem_v_d;
  logic [4:0]      alu_rd_q, alu_rd_d, mem_rd_q, mem_rd_d;
  logic [XLEN-1:0] alu_data_q, alu_data_d, mem_data_q, mem_data_d;
  src_e            rr_q, rr_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [31:0]     busy_clr_q, busy_clr_d;
  logic            grant_alu, grant_mem, alu_xfer, mem_xfer;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0]     retire_q, retire_d;
`endif
  always_comb begin
    grant_alu  = !flush && alu_v_q && (!mem_v_q || rr_q == SRC_ALU);
    grant_mem  = !flush && mem_v_q && (!alu_v_q || rr_q == SRC_MEM);
    alu_ok_o   = !flush && (!alu_v_q || grant_alu);
    mem_ok_o   = !flush && (!mem_v_q || grant_mem);
    alu_xfer   = alu_valid_i && alu_ok_o;
    mem_xfer   = mem_valid_i && mem_ok_o;
    // writes to x0 are accepted but never become valid, so they vanish here
    alu_v_d    = flush ? 1'b0 : alu_xfer ? (alu_rd_i != 5'd0) : (alu_v_q && !grant_alu);
    mem_v_d    = flush ? 1'b0 : mem_xfer ? (mem_rd_i != 5'd0) : (mem_v_q && !grant_mem);
    alu_rd_d   = alu_xfer ? alu_rd_i : alu_rd_q;
    mem_rd_d   = mem_xfer ? mem_rd_i : mem_rd_q;
    alu_data_d = alu_xfer ? alu_result_i : alu_data_q;
    mem_data_d = mem_xfer ? mem_result_i : mem_data_q;
    rr_d       = grant_alu ? SRC_MEM : grant_mem ? SRC_ALU : rr_q;
    rf_we_d    = grant_alu || grant_mem;
    rf_waddr_d = grant_alu ? alu_rd_q : grant_mem ? mem_rd_q : rf_waddr_q;
    rf_wdata_d = grant_alu ? alu_data_q : grant_mem ? mem_data_q : rf_wdata_q;
    busy_clr_d = rf_we_d ? (32'd1 << rf_waddr_d) : 32'd0;
`ifdef WB_RETIRE_CNT_EN
    retire_d   = retire_q + {31'd0, rf_we_d};
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_v_q    <= 1'b0;
      mem_v_q    <= 1'b0;
      alu_rd_q   <= '0;
      mem_rd_q   <= '0;
      alu_data_q <= '0;
      mem_data_q <= '0;
      rr_q       <= SRC_ALU;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_clr_q <= '0;
`ifdef WB_RETIRE_CNT_EN
      retire_q   <= '0;
`endif
    end else begin
      alu_v_q    <= alu_v_d;
      mem_v_q    <= mem_v_d;
      alu_rd_q   <= alu_rd_d;
      mem_rd_q   <= mem_rd_d;
      alu_data_q <= alu_data_d;
      mem_data_q <= mem_data_d;
      rr_q       <= rr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_clr_q <= busy_clr_d;
`ifdef WB_RETIRE_CNT_EN
      retire_q   <= retire_d;
`endif
    end
  end
  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign busy_clr_o = busy_clr_q;
`ifdef WB_RETIRE_CNT_EN
  assign retire_cnt_o = retire_q;
`endif
endmodule
